// File: rtl/spart_prog_writer.sv
// Loads a length-prefixed, XOR-checksummed program image from a SPART byte stream
// into a 16-bit-word program memory, one write strobe per assembled word.
module spart_prog_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state   | meaning
  // IDLE    | waiting for start
  // LEN_HI  | expecting word count, high byte
  // LEN_LO  | expecting word count, low byte
  // DATA_HI | expecting instruction high byte
  // DATA_LO | expecting instruction low byte (write follows)
  // CHECK   | expecting checksum byte
  // DONE    | load complete, checksum good
  // ERR     | oversize length, timeout or bad checksum
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  localparam int          CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << (ADDR_WIDTH - 1);

  state_t                state, state_nxt;
  logic [7:0]            len_hi, data_hi, acc;
  logic [15:0]           len;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CNT_W-1:0]      idle_cnt;
  logic [15:0]           len_rx;
  logic                  last_word, timed_out;

  assign len_rx    = {len_hi, rx_data};
  assign last_word = (32'(idx) + 32'd1) == 32'(len);
  // Fires on the idle cycle that would bring the count up to TIMEOUT.
  assign timed_out = busy && !rx_valid && (32'(idle_cnt) == 32'(TIMEOUT - 1));
  assign mem_en    = mem_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
      LEN_HI:  if (rx_valid) state_nxt = LEN_LO;
      LEN_LO:
        if (rx_valid) begin
          if (len_rx == 16'd0)              state_nxt = CHECK;
          else if (32'(len_rx) > MAX_WORDS) state_nxt = ERR;
          else                              state_nxt = DATA_HI;
        end
      DATA_HI: if (rx_valid) state_nxt = DATA_LO;
      DATA_LO: if (rx_valid) state_nxt = last_word ? CHECK : DATA_HI;
      CHECK:   if (rx_valid) state_nxt = (rx_data == acc) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = ERR;
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: busy = 1'b1;
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx       <= '0;
      acc       <= '0;
      idle_cnt  <= '0;
      len_hi    <= '0;
      len       <= '0;
      data_hi   <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (!busy) begin
        // A byte arriving together with start is deliberately dropped here.
        if (start) begin
          idx      <= '0;
          acc      <= '0;
          idle_cnt <= '0;
        end
      end else if (rx_valid) begin
        idle_cnt <= '0;
        case (state)
          LEN_HI:  len_hi <= rx_data;
          LEN_LO:  len    <= len_rx;
          DATA_HI: begin
            data_hi <= rx_data;
            acc     <= acc ^ rx_data;
          end
          DATA_LO: begin
            mem_wr    <= 1'b1;
            mem_wdata <= {data_hi, rx_data};
            mem_addr  <= {idx[ADDR_WIDTH-2:0], 1'b0};
            idx       <= idx + 1'b1;
            acc       <= acc ^ rx_data;
          end
          default: ;
        endcase
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
